// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control sequencer: state encodings,
// opcode and ALUop constants, and the packed control-output bundle that the
// decoder produces and the top level fans out to its ports.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_SLT = 3'b011;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_inc;
    logic       pc_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       funct;
    logic       t0;
    logic       t1;
    logic       halted;
    logic       fault;
  } ctrl_t;

  function automatic logic [2:0] opcode_of(input logic [7:0] ir);
    return ir[7:5];
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_decode.sv
// Combinational control decoder for the multicycle sequencer.
// Ports:
//   state     - current sequencer state
//   ir        - latched instruction register
//   zero      - ALU zero flag (BEQ branch decision in EXEC)
//   mem_ready - memory completes the current access this cycle
//   ctrl      - all datapath enables and ALUctrl inputs
// Requests are Moore-decoded from state and IR; only ir_write/pc_inc
// (mem_ready) and the BEQ pc_write (zero) depend on inputs within the cycle.
module multicycle_ctrl_fsm_ctrl_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [7:0] ir,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic [2:0] op;
  logic       unused_ir_bits;

  assign op             = opcode_of(ir);
  // IR[4:3] carry register/immediate fields the controller does not decode.
  assign unused_ir_bits = ^ir[4:3];

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
        ctrl.pc_inc   = mem_ready;
      end
      S_DECODE: begin
        if (op == OP_JMP) ctrl.pc_write = 1'b1;
      end
      S_EXEC: begin
        // ALU fields are only ever non-zero here.
        case (op)
          OP_RTYPE: begin
            ctrl.alu_op = ALUOP_R;
            ctrl.funct  = ir[0];
            ctrl.t0     = ir[1];
            ctrl.t1     = ir[2];
          end
          OP_ADDI, OP_LW, OP_SW: ctrl.alu_op = ALUOP_ADD;
          OP_BEQ: begin
            ctrl.alu_op   = ALUOP_SUB;
            ctrl.pc_write = zero;
          end
          OP_SLT: ctrl.alu_op = ALUOP_SLT;
          default: ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) ctrl.mem_write = 1'b1;
        else             ctrl.mem_read  = 1'b1;
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (op == OP_LW);
      end
      S_HALT:  ctrl.halted = 1'b1;
      S_FAULT: ctrl.fault  = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle main control sequencer for the 8-bit computer.
// Steps FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and ALUctrl inputs,
// bounds every memory wait and counts retired instructions.
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   start                - leave IDLE and begin fetching (ignored elsewhere)
//   instr                - instruction word, captured when mem_ready in FETCH
//   mem_ready, zero      - memory completion, ALU zero flag
//   mem_read..mem_to_reg - datapath enables / memory requests
//   alu_op, funct, t0, t1- ALUctrl inputs (non-zero only in EXEC)
//   halted, fault        - absorbing HALT / FAULT indications
//   retired              - completed-instruction count, wraps mod 2^CNT_W
//   fsm_state            - current state, for observation
// Memory handshake: a request (mem_read or mem_write) is held every cycle the
// sequencer sits in FETCH or MEM; the access completes in the cycle mem_ready
// is high while the request is asserted, and the state advances on that edge.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       alu_op,
  output logic             funct,
  output logic             t0,
  output logic             t1,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output state_t           fsm_state
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_next;
  logic [7:0]        ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        op;
  logic              retire;
  logic              wait_expired;
  ctrl_t             ctrl;

  assign op = opcode_of(ir);
  // The last permitted wait cycle without mem_ready; mem_ready in that same
  // cycle still completes normally.
  assign wait_expired = (wait_cnt == WAIT_LAST) && !mem_ready;

  multicycle_ctrl_fsm_ctrl_decode u_decode (
    .state     (state),
    .ir        (ir),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)         state_next = S_DECODE;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        case (op)
          OP_JMP: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_HALT: begin
            retire     = 1'b1;
            state_next = S_HALT;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op)
          OP_BEQ: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_LW, OP_SW: state_next = S_MEM;
          default:      state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_expired) begin
          state_next = S_FAULT;
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (ctrl.ir_write) ir <= instr;
      // FETCH and MEM are only ever entered from another state, so clearing
      // on every transition clears on entry to both.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign pc_inc     = ctrl.pc_inc;
  assign pc_write   = ctrl.pc_write;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_op     = ctrl.alu_op;
  assign funct      = ctrl.funct;
  assign t0         = ctrl.t0;
  assign t1         = ctrl.t1;
  assign halted     = ctrl.halted;
  assign fault      = ctrl.fault;
  assign fsm_state  = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle stimulus and expected control
// vectors are queued together, then replayed one cycle at a time.
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, mem_ready, zero;
  logic [7:0] instr;

  logic        mem_read, mem_write, ir_write, pc_inc, pc_write, reg_write, mem_to_reg;
  logic [2:0]  alu_op;
  logic        funct, t0, t1, halted, fault;
  logic [15:0] retired;
  state_t      fsm_state;

  logic        w4_mem_read, w4_mem_write, w4_ir_write, w4_pc_inc, w4_pc_write;
  logic        w4_reg_write, w4_mem_to_reg, w4_funct, w4_t0, w4_t1, w4_halted, w4_fault;
  logic [2:0]  w4_alu_op;
  logic [3:0]  w4_retired;
  state_t      w4_fsm_state;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_inc(pc_inc), .pc_write(pc_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .funct(funct), .t0(t0), .t1(t1),
    .halted(halted), .fault(fault), .retired(retired), .fsm_state(fsm_state)
  );

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(8), .CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .mem_read(w4_mem_read), .mem_write(w4_mem_write), .ir_write(w4_ir_write),
    .pc_inc(w4_pc_inc), .pc_write(w4_pc_write), .reg_write(w4_reg_write),
    .mem_to_reg(w4_mem_to_reg), .alu_op(w4_alu_op), .funct(w4_funct), .t0(w4_t0),
    .t1(w4_t1), .halted(w4_halted), .fault(w4_fault), .retired(w4_retired),
    .fsm_state(w4_fsm_state)
  );

  // ---------------- constants ----------------
  localparam logic [7:0] I_RTYPE = 8'b000_00_111;
  localparam logic [7:0] I_ADDI  = 8'b001_00000;
  localparam logic [7:0] I_LW    = 8'b010_00000;
  localparam logic [7:0] I_SW    = 8'b011_00000;
  localparam logic [7:0] I_BEQ   = 8'b100_00000;
  localparam logic [7:0] I_SLT   = 8'b101_00000;
  localparam logic [7:0] I_JMP   = 8'b110_00000;
  localparam logic [7:0] I_HALT  = 8'b111_00000;

  // {mem_read, mem_write, ir_write, pc_inc, pc_write, reg_write, mem_to_reg}
  localparam logic [6:0] R_NONE  = 7'b0000000;
  localparam logic [6:0] R_FWAIT = 7'b1000000;
  localparam logic [6:0] R_FGO   = 7'b1011000;
  localparam logic [6:0] R_PCW   = 7'b0000100;
  localparam logic [6:0] R_MRD   = 7'b1000000;
  localparam logic [6:0] R_MWR   = 7'b0100000;
  localparam logic [6:0] R_WB    = 7'b0000010;
  localparam logic [6:0] R_WBLW  = 7'b0000011;

  // {alu_op, funct, t0, t1}
  localparam logic [5:0] A_NONE = 6'b000_000;
  localparam logic [5:0] A_R111 = 6'b010_111;
  localparam logic [5:0] A_SUB  = 6'b001_000;
  localparam logic [5:0] A_SLT  = 6'b011_000;

  localparam logic [1:0] HF_NONE  = 2'b00;
  localparam logic [1:0] HF_HALT  = 2'b10;
  localparam logic [1:0] HF_FAULT = 2'b01;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [11:0] stim_q[$];

  function automatic logic [17:0] ev(input state_t s, input logic [6:0] rq,
                                     input logic [5:0] al, input logic [1:0] hf);
    return {s, rq, al, hf};
  endfunction

  function automatic logic [11:0] stim(input logic r, input logic s, input logic m,
                                       input logic z, input logic [7:0] i);
    return {r, s, m, z, i};
  endfunction

  function automatic logic [17:0] observe();
    return {fsm_state, mem_read, mem_write, ir_write, pc_inc, pc_write, reg_write,
            mem_to_reg, alu_op, funct, t0, t1, halted, fault};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add(input logic [11:0] s, input logic [17:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [11:0] s);
    {reset, start, mem_ready, zero, instr} = s;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; instr = 8'h00;
    advance();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [17:0] obs, e;
    int cyc = 0;
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1; zero = 1'b1; instr = I_RTYPE;
    advance();
    add(stim(1, 1, 1, 1, I_RTYPE), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 1, I_RTYPE), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 1, I_RTYPE), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd0) begin errors++; $display("FAIL reset retired: got %0d expected 0", retired); end
    checks++;
    if (w4_retired !== 4'd0) begin errors++; $display("FAIL reset retired_w4: got %0d expected 0", w4_retired); end
  endtask

  task automatic test_rtype();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, 0, I_RTYPE), ev(S_IDLE,   R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_RTYPE), ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_RTYPE), ev(S_DECODE, R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_RTYPE), ev(S_EXEC,   R_NONE,  A_R111, HF_NONE));
    add(stim(0, 0, 1, 0, I_RTYPE), ev(S_WB,     R_WB,    A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_RTYPE), ev(S_FETCH,  R_FWAIT, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rtype cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd1) begin errors++; $display("FAIL rtype retired: got %0d expected 1", retired); end
  endtask

  task automatic test_lw_wait();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, 0, I_LW), ev(S_IDLE,   R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_LW), ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_DECODE, R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_EXEC,   R_NONE,  A_NONE, HF_NONE));
    for (int k = 0; k < 3; k++)
      add(stim(0, 0, 0, 0, I_LW), ev(S_MEM, R_MRD, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_LW), ev(S_MEM,    R_MRD,   A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_WB,     R_WBLW,  A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_FETCH,  R_FWAIT, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL lw cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd1) begin errors++; $display("FAIL lw retired: got %0d expected 1", retired); end
  endtask

  task automatic test_beq(input logic z);
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, z, I_BEQ), ev(S_IDLE,   R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, z, I_BEQ), ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 1, z, I_BEQ), ev(S_DECODE, R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, z, I_BEQ), ev(S_EXEC,   z ? R_PCW : R_NONE, A_SUB, HF_NONE));
    add(stim(0, 0, 0, z, I_BEQ), ev(S_FETCH,  R_FWAIT, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL beq z=%0d cyc %0d: got %b expected %b", z, cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd1) begin errors++; $display("FAIL beq z=%0d retired: got %0d expected 1", z, retired); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, 0, I_SW),   ev(S_IDLE,   R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SW),   ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SW),   ev(S_DECODE, R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SW),   ev(S_EXEC,   R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SW),   ev(S_MEM,    R_MWR,   A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SLT),  ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SLT),  ev(S_DECODE, R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SLT),  ev(S_EXEC,   R_NONE,  A_SLT,  HF_NONE));
    add(stim(0, 0, 1, 0, I_SLT),  ev(S_WB,     R_WB,    A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_ADDI), ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_ADDI), ev(S_DECODE, R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_ADDI), ev(S_EXEC,   R_NONE,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_ADDI), ev(S_WB,     R_WB,    A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_ADDI), ev(S_FETCH,  R_FWAIT, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd3) begin errors++; $display("FAIL b2b retired: got %0d expected 3", retired); end
  endtask

  task automatic test_fetch_timeout();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 0, 0, I_RTYPE), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    for (int k = 0; k < 8; k++)
      add(stim(0, 0, 0, 0, I_RTYPE), ev(S_FETCH, R_FWAIT, A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_RTYPE), ev(S_FAULT, R_NONE, A_NONE, HF_FAULT));
    add(stim(0, 1, 1, 1, I_RTYPE), ev(S_FAULT, R_NONE, A_NONE, HF_FAULT));
    add(stim(0, 1, 1, 1, I_RTYPE), ev(S_FAULT, R_NONE, A_NONE, HF_FAULT));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fetch_timeout cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd0) begin errors++; $display("FAIL fetch_timeout retired: got %0d expected 0", retired); end
    do_reset();
    add(stim(0, 0, 1, 1, I_RTYPE), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fault_reset: got %b expected %b", obs, e); end
      advance();
    end
  endtask

  task automatic test_timeout_edge();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 0, 0, I_JMP), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    for (int k = 0; k < 7; k++)
      add(stim(0, 0, 0, 0, I_JMP), ev(S_FETCH, R_FWAIT, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_JMP), ev(S_FETCH,  R_FGO,   A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_JMP), ev(S_DECODE, R_PCW,   A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_JMP), ev(S_FETCH,  R_FWAIT, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout_edge cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd1) begin errors++; $display("FAIL timeout_edge retired: got %0d expected 1", retired); end
  endtask

  task automatic test_mem_timeout();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 0, 0, I_SW), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    for (int k = 0; k < 5; k++)
      add(stim(0, 0, 0, 0, I_SW), ev(S_FETCH, R_FWAIT, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_SW), ev(S_FETCH,  R_FGO,  A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_SW), ev(S_DECODE, R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_SW), ev(S_EXEC,   R_NONE, A_NONE, HF_NONE));
    for (int k = 0; k < 8; k++)
      add(stim(0, 0, 0, 0, I_SW), ev(S_MEM, R_MWR, A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_SW), ev(S_FAULT, R_NONE, A_NONE, HF_FAULT));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_timeout cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd0) begin errors++; $display("FAIL mem_timeout retired: got %0d expected 0", retired); end
  endtask

  task automatic test_halt();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, 0, I_HALT), ev(S_IDLE,   R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_HALT), ev(S_FETCH,  R_FGO,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_HALT), ev(S_DECODE, R_NONE, A_NONE, HF_NONE));
    add(stim(0, 1, 1, 1, I_HALT), ev(S_HALT,   R_NONE, A_NONE, HF_HALT));
    add(stim(0, 0, 0, 0, I_HALT), ev(S_HALT,   R_NONE, A_NONE, HF_HALT));
    add(stim(0, 1, 1, 1, I_HALT), ev(S_HALT,   R_NONE, A_NONE, HF_HALT));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL halt cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd1) begin errors++; $display("FAIL halt retired: got %0d expected 1", retired); end
  endtask

  task automatic test_reset_mid_lw();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, 0, I_LW), ev(S_IDLE,   R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_LW), ev(S_FETCH,  R_FGO,  A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_DECODE, R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_EXEC,   R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 0, 0, I_LW), ev(S_MEM,    R_MRD,  A_NONE, HF_NONE));
    add(stim(1, 0, 0, 0, I_LW), ev(S_MEM,    R_MRD,  A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_LW), ev(S_IDLE,   R_NONE, A_NONE, HF_NONE));
    add(stim(0, 0, 1, 0, I_LW), ev(S_IDLE,   R_NONE, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid_lw cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd0) begin errors++; $display("FAIL reset_mid_lw retired: got %0d expected 0", retired); end
  endtask

  task automatic test_retired_wrap();
    logic [17:0] obs, e;
    int cyc = 0;
    do_reset();
    add(stim(0, 1, 1, 0, I_JMP), ev(S_IDLE, R_NONE, A_NONE, HF_NONE));
    for (int k = 0; k < 17; k++) begin
      add(stim(0, 0, 1, 0, I_JMP), ev(S_FETCH,  R_FGO, A_NONE, HF_NONE));
      add(stim(0, 0, 1, 0, I_JMP), ev(S_DECODE, R_PCW, A_NONE, HF_NONE));
    end
    add(stim(0, 0, 0, 0, I_JMP), ev(S_FETCH, R_FWAIT, A_NONE, HF_NONE));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      obs = observe(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL wrap cyc %0d: got %b expected %b", cyc, obs, e); end
      cyc++; advance();
    end
    checks++;
    if (retired !== 16'd17) begin errors++; $display("FAIL wrap retired: got %0d expected 17", retired); end
    checks++;
    if (w4_retired !== 4'd1) begin errors++; $display("FAIL wrap retired_w4: got %0d expected 1", w4_retired); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_back_to_back();
    test_fetch_timeout();
    test_timeout_edge();
    test_mem_timeout();
    test_halt();
    test_reset_mid_lw();
    test_retired_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle main control sequencer for the 8-bit computer.
- Fetches each instruction over a ready-handshaked memory port, then decodes the opcode and steps through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath enables and the ALU control inputs (alu_op, funct, t0, t1) that feed ALUctrl.
- Provides a bounded memory-wait timeout and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 8, max cycles to wait for mem_ready in FETCH or MEM; the limit is exceeded -> FAULT.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  leave IDLE and begin fetching
instr  input  8  instruction word from memory, valid when mem_ready=1 in FETCH
mem_ready  input  1  memory completes the current access this cycle
zero  input  1  ALU zero flag, sampled in EXEC for BEQ
mem_read  output  1  memory read request (FETCH, or MEM for LW)
mem_write  output  1  memory write request (MEM for SW)
ir_write  output  1  load instruction register
pc_inc  output  1  PC <= PC+1
pc_write  output  1  PC <= branch/jump target
reg_write  output  1  register file write
mem_to_reg  output  1  writeback source select: 1 = memory, 0 = ALU
alu_op  output  3  to ALUctrl
funct  output  1  to ALUctrl
t0  output  1  to ALUctrl
t1  output  1  to ALUctrl
halted  output  1  in HALT state
fault  output  1  in FAULT state
retired  output  CNT_W  completed-instruction count

Behaviour:
- Reset: synchronous, active-high. On the next rising edge: state=IDLE, IR=0, wait counter=0, retired=0. Every output is 0 while reset is high and in IDLE.
- Reset asserted mid-operation abandons the access in flight; requests drop on the following edge.
- Opcode = IR[7:5]:
  - 000 RTYPE: alu_op=010, funct=IR[0], t0=IR[1], t1=IR[2]
  - 001 ADDI: alu_op=000
  - 010 LW: alu_op=000
  - 011 SW: alu_op=000
  - 100 BEQ: alu_op=001
  - 101 SLT: alu_op=011
  - 110 JMP
  - 111 HALT
- ALU fields are nonzero only in EXEC. In every other state alu_op=000 and funct=t0=t1=0.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH:
  - mem_read=1 every cycle.
  - mem_ready=1: ir_write=1 and pc_inc=1 in that same cycle, IR<=instr, -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, reads registers.
  - JMP: pc_write=1, retire, -> FETCH.
  - HALT: retire, -> HALT.
  - All other opcodes -> EXEC.
- EXEC: one cycle, ALU fields driven.
  - BEQ: pc_write=zero, retire, -> FETCH.
  - LW/SW -> MEM.
  - RTYPE/ADDI/SLT -> WB.
- MEM:
  - LW: mem_read=1. SW: mem_write=1.
  - On mem_ready: SW retires and -> FETCH; LW -> WB.
- WB: one cycle, reg_write=1, mem_to_reg=1 for LW, retire, -> FETCH.
- Zero-wait-state latency:
  - JMP and HALT: 2 cycles.
  - BEQ: 3 cycles.
  - RTYPE/ADDI/SLT and SW: 4 cycles.
  - LW: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH or MEM. Increments each cycle in that state while mem_ready=0.
  - Counter = MEM_TIMEOUT-1 with mem_ready=0 -> FAULT.
  - mem_ready=1 in that same cycle wins: normal transition, no fault.
- HALT: halted=1, all other controls 0. FAULT: fault=1, all other controls 0. Both are absorbing states; only reset exits them.
- start is ignored outside IDLE.
- retired increments by 1 on each retire event, HALT included; never on FAULT. Wraps modulo 2^CNT_W.
- Request outputs are Moore-decoded from state and IR. ir_write, pc_inc and pc_write are gated by mem_ready or zero within the cycle.

Decomposition:
- Shared package holds:
  - state encodings: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT
  - opcode constants: OP_RTYPE through OP_HALT
  - ALUop constants: ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_R=010, ALUOP_SLT=011
- One natural sub-module: ctrl_decode, a combinational function (state, IR, zero, mem_ready) -> control outputs. The FSM, wait counter and retired counter stay in the top level.

Test Plan:
- reset=1 for 2 cycles, then start=1, instr=8'b000_00_111, mem_ready=1 always -> FETCH, DECODE, EXEC, WB. In EXEC: alu_op=010, funct=1, t0=1, t1=1. reg_write=1 in WB; retired=1 after 4 cycles.
- LW (8'b010_00000) with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles in MEM, then WB with mem_to_reg=1; total 8 cycles, retired increments once.
- BEQ (8'b100_00000): zero=1 -> pc_write=1 in EXEC. Repeat with zero=0 -> pc_write=0. Both return to FETCH after 3 cycles, alu_op=001.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=8 -> fault=1 on the 9th cycle, counted from the first FETCH cycle after start. retired unchanged. fault stays high until reset, then IDLE with all outputs 0.
- mem_ready rises exactly on the timeout cycle (counter=7) -> normal DECODE, fault=0.
- HALT (8'b111_00000) -> halted=1 two cycles after start, retired=1. start pulses ignored. Reset asserted mid-LW in MEM -> IDLE and mem_read=0 after the next edge; then CNT_W=4 run of 17 JMPs -> retired=1 (wrap).
